fb_arbiter: RTL
===============

Name: fb_arbiter

Overview:
- Shares the single-port character frame-buffer RAM (80 x 60 = 4800 cells, 13-bit address) between two requesters.
- Requester 1 is the display fetch path: the row address generator that feeds the display FIFO.
- Requester 2 is the host write/read port used to update screen contents.
- Display has priority, to protect FIFO refill. A starvation counter guarantees host progress. Read data is returned to the owning requester with fixed latency.

Parameters:
- ADDR_W, 13, frame-buffer address width
- DATA_W, 8, character cell width
- FB_DEPTH, 4800, number of valid cells; addresses >= FB_DEPTH are out of range
- STARVE_LIMIT, 8, host wait cycles before host is forced ahead of display (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- disp_req  in  1  display read request, held until granted
- disp_addr  in  ADDR_W  display read address
- disp_gnt  out  1  display request accepted this cycle (combinational)
- disp_rvalid  out  1  display read data valid
- disp_rdata  out  DATA_W  display read data
- host_req  in  1  host request, held until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host request accepted this cycle (combinational)
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- host_err  out  1  one-cycle pulse: accepted host access was out of range
- mem_en  out  1  RAM enable (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en & ~mem_we

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- Reset values: all outputs 0, starvation counter 0, read-tag pipeline cleared.
- Handshake:
  - A transfer occurs at a posedge where req & gnt.
  - Requesters hold req, addr and data stable until granted; a new request may be presented the next cycle.
  - At most one grant per cycle; 100% throughput is achievable.
- Grant rule (combinational from req inputs and registered counter):
  - force_host = (wait_cnt >= STARVE_LIMIT).
  - disp_gnt = disp_req & ~(host_req & force_host).
  - host_gnt = host_req & (~disp_req | force_host).
- Starvation counter wait_cnt (4 bits, saturating at 15):
  - Increments when host_req & ~host_gnt.
  - Clears on host transfer, and when host_req = 0.
- Command issue (cycle T = transfer cycle; RAM signals at T+1):
  - mem_en = 1 only for in-range accesses.
  - mem_we = host_we for host, 0 for display.
  - mem_addr and mem_wdata are taken from the granted requester.
- Out-of-range (addr >= FB_DEPTH):
  - No RAM access.
  - Host access: host_err pulses at T+1.
  - A read of either requester still returns rvalid with rdata = 0 at normal latency.
- Read return:
  - A two-stage tag pipeline {valid, owner, in_range} tracks each read.
  - rvalid and rdata for the owner are registered at T+2 (two cycles after the transfer edge).
  - The non-owner's rdata holds its previous value.
- Host writes produce no rvalid.
- Back-to-back mixed reads return in issue order; each rvalid pulse lasts one cycle.
- Simultaneous requests with wait_cnt < STARVE_LIMIT: display wins and the host counter increments.
- Reset mid-operation: in-flight reads are discarded (no rvalid after reset) and mem_en is forced 0 from the next edge.

Decomposition:
- Shared package fb_pkg holds:
  - FB_COLS = 80, FB_ROWS = 60, FB_DEPTH = 4800, ADDR_W = 13, DATA_W = 8
  - Owner encoding constants OWN_DISP = 0, OWN_HOST = 1
- One natural sub-module, fb_rd_return: the two-stage tag pipeline plus rdata/rvalid routing and zero-substitution.
- The grant logic and counter stay in the top level.

Test Plan:
- Display only, disp_req held high, addresses 0..79: disp_gnt every cycle; mem_addr 0..79 on consecutive cycles; disp_rvalid and data 2 cycles after each transfer, in order.
- Host write addr 100 = 8'h41, then host read addr 100, display idle: mem_we = 1 then 0; host_rvalid with host_rdata = 8'h41 at T+2 of the read; no disp_rvalid.
- Display held continuously plus host_req held from cycle 0: host granted exactly on the 9th cycle (wait_cnt = 8); display stalled that one cycle and resumes the next.
- Host write to addr 4800 and host read of addr 8191: both granted; no mem_en; host_err pulses twice; the read returns host_rvalid with host_rdata = 0.
- Interleaved display read of addr 5 and host read of addr 6 on adjacent cycles (RAM preloaded 5 -> 8'h11, 6 -> 8'h22): disp_rdata = 8'h11, then host_rdata = 8'h22 one cycle later; no cross-routing.
- Assert rst the cycle after a read transfer: no rvalid on either port afterwards; all outputs 0; the first grant after reset release follows the normal rule.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer geometry, widths, owner encoding and read-tag type
package fb_pkg;
  localparam int FB_COLS = 80;
  localparam int FB_ROWS = 60;
  localparam int FB_DEPTH = FB_COLS * FB_ROWS;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam logic OWN_DISP = 1'b0;
  localparam logic OWN_HOST = 1'b1;
  typedef struct packed {
    logic valid;
    logic owner;
    logic in_range;
  } rd_tag_t;
endpackage

// File: rtl/fb_rd_return.sv
// fb_rd_return: two-stage read tag pipeline routing RAM read data (or zero) to its owner; ports: clk, rst, issue/owner/in_range at transfer, mem_rdata, per-owner rvalid/rdata
module fb_rd_return #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              owner,
  input  logic              in_range,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata
);
  import fb_pkg::*;
  rd_tag_t s1, s2;
  logic [DATA_W-1:0] rd;
  assign rd = s2.in_range ? mem_rdata : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      disp_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      disp_rdata <= '0;
      host_rdata <= '0;
    end else begin
      s1 <= '{valid: issue, owner: owner, in_range: in_range};
      s2 <= s1;
      disp_rvalid <= s2.valid & (s2.owner == OWN_DISP);
      host_rvalid <= s2.valid & (s2.owner == OWN_HOST);
      if (s2.valid & (s2.owner == OWN_DISP)) disp_rdata <= rd;
      if (s2.valid & (s2.owner == OWN_HOST)) host_rdata <= rd;
    end
  end
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: display-priority arbiter with host starvation guard for the single-port frame-buffer RAM; ports: display/host req-gnt-rvalid interfaces, host_err, registered RAM command
module fb_arbiter #(
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int DATA_W = fb_pkg::DATA_W,
  parameter int FB_DEPTH = fb_pkg::FB_DEPTH,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import fb_pkg::*;
  logic [3:0] wait_cnt;
  logic force_host, any_gnt, in_range;
  logic [ADDR_W-1:0] sel_addr;
  // grants are suppressed during reset so nothing is accepted that the flush would drop
  always_comb begin
    force_host = wait_cnt >= 4'(STARVE_LIMIT);
    disp_gnt = ~rst & disp_req & ~(host_req & force_host);
    host_gnt = ~rst & host_req & (~disp_req | force_host);
    any_gnt = disp_gnt | host_gnt;
    sel_addr = host_gnt ? host_addr : disp_addr;
    in_range = sel_addr < ADDR_W'(FB_DEPTH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      host_err <= 1'b0;
    end else begin
      wait_cnt <= (host_req & ~host_gnt) ? wait_cnt + {3'b0, wait_cnt != 4'hf} : '0;
      mem_en <= any_gnt & in_range;
      mem_we <= host_gnt & host_we & in_range;
      if (any_gnt) begin
        mem_addr <= sel_addr;
        mem_wdata <= host_gnt ? host_wdata : '0;
      end
      host_err <= host_gnt & ~in_range;
    end
  end
  fb_rd_return #(.DATA_W(DATA_W)) u_rd (
    .clk(clk),
    .rst(rst),
    .issue(any_gnt & ~(host_gnt & host_we)),
    .owner(host_gnt ? OWN_HOST : OWN_DISP),
    .in_range(in_range),
    .mem_rdata(mem_rdata),
    .disp_rvalid(disp_rvalid),
    .disp_rdata(disp_rdata),
    .host_rvalid(host_rvalid),
    .host_rdata(host_rdata)
  );
endmodule
